// File: rtl/reg_bank_param_if.sv
// Bus bundle for reg_bank_param: two read ports, one write port, clear handshake and debug dump.
// The master modport is the datapath side and the slave modport is the register bank.
interface reg_bank_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [ADDR_W-1:0]       readRegister1;
   logic [ADDR_W-1:0]       readRegister2;
   logic [DATA_W-1:0]       readData1;
   logic [DATA_W-1:0]       readData2;
   logic                    regWrite;
   logic [ADDR_W-1:0]       writeRegister;
   logic [DATA_W-1:0]       writeData;
   logic                    clrReq;
   logic                    clrBusy;
   logic                    clrDone;
   logic                    wrDrop;
   logic [DATA_W*DEPTH-1:0] dataLookUp;

   modport master (
      output readRegister1, readRegister2, regWrite, writeRegister, writeData, clrReq,
      input  readData1, readData2, clrBusy, clrDone, wrDrop, dataLookUp
   );

   modport slave (
      input  readRegister1, readRegister2, regWrite, writeRegister, writeData, clrReq,
      output readData1, readData2, clrBusy, clrDone, wrDrop, dataLookUp
   );
endinterface

// File: rtl/reg_bank_param.sv
// Parametrised register bank with combinational reads, one write port and a one-entry-per-cycle clear engine.
// Optional write-to-read forwarding is enabled by defining REGBANK_BYPASS_EN.
module reg_bank_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   reg_bank_param_if.slave    bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} clrState_t;

   clrState_t         state;
   logic [DATA_W-1:0] regFile [DEPTH];
   logic [ADDR_W-1:0] clrPtr;
   logic              clrBusyQ;
   logic              clrDoneQ;
   logic              wrDropQ;
   logic              zeroMasked;
   logic              writeAccept;
   logic [DATA_W-1:0] readData1Q;
   logic [DATA_W-1:0] readData2Q;

   // Writes to a hard-wired zero register are dropped silently, without a wrDrop pulse.
   assign zeroMasked  = (ZERO_REG != 0) && (bus.writeRegister == '0);
   assign writeAccept = bus.regWrite && (state != CLEAR) && !zeroMasked;

   always_comb begin
      readData1Q = regFile[bus.readRegister1];
      if ((ZERO_REG != 0) && (bus.readRegister1 == '0)) readData1Q = '0;
`ifdef REGBANK_BYPASS_EN
      if (writeAccept && (bus.readRegister1 == bus.writeRegister)) readData1Q = bus.writeData;
`endif
   end

   always_comb begin
      readData2Q = regFile[bus.readRegister2];
      if ((ZERO_REG != 0) && (bus.readRegister2 == '0)) readData2Q = '0;
`ifdef REGBANK_BYPASS_EN
      if (writeAccept && (bus.readRegister2 == bus.writeRegister)) readData2Q = bus.writeData;
`endif
   end

   assign bus.readData1 = readData1Q;
   assign bus.readData2 = readData2Q;

   // Debug dump is never forwarded: R[0] lands in the most significant slice.
   for (genvar i = 0; i < DEPTH; i++) begin : gDump
      if ((ZERO_REG != 0) && (i == 0)) begin : gZero
         assign bus.dataLookUp[(DEPTH-1-i)*DATA_W +: DATA_W] = '0;
      end else begin : gReg
         assign bus.dataLookUp[(DEPTH-1-i)*DATA_W +: DATA_W] = regFile[i];
      end
   end

   // Clear engine and write port share one process so a sweep cycle can never race a write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regFile[i] <= '0;
         state    <= IDLE;
         clrPtr   <= '0;
         clrBusyQ <= 1'b0;
         clrDoneQ <= 1'b0;
         wrDropQ  <= 1'b0;
      end else begin
         clrDoneQ <= 1'b0;
         wrDropQ  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.clrReq) begin
                  state    <= CLEAR;
                  clrPtr   <= '0;
                  clrBusyQ <= 1'b1;
               end
            end
            CLEAR: begin
               regFile[clrPtr] <= '0;
               if (clrPtr == LAST_ADDR) begin
                  state    <= DONE;
                  clrBusyQ <= 1'b0;
                  clrDoneQ <= 1'b1;
               end else begin
                  clrPtr <= clrPtr + ADDR_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               clrBusyQ <= 1'b0;
            end
         endcase

         if (bus.regWrite && (state == CLEAR)) begin
            wrDropQ <= 1'b1;
         end else if (writeAccept) begin
            regFile[bus.writeRegister] <= bus.writeData;
         end
      end
   end

   assign bus.clrBusy = clrBusyQ;
   assign bus.clrDone = clrDoneQ;
   assign bus.wrDrop  = wrDropQ;
endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench for reg_bank_param: bank A is 8x8 without zero register, bank B is 16x8 with ZERO_REG=1.
// Expected values come from per-bank reference arrays and are queued before the DUT is sampled.
module tb_reg_bank_param;
   logic clk = 1'b0;
   logic rstA;
   logic rstB;

   always #5 clk = ~clk;

   reg_bank_param_if #(.DATA_W(8), .ADDR_W(3)) busA ();
   reg_bank_param_if #(.DATA_W(8), .ADDR_W(4)) busB ();

   reg_bank_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dutA (.clk(clk), .rst_n(rstA), .bus(busA));
   reg_bank_param #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1)) dutB (.clk(clk), .rst_n(rstB), .bus(busB));

   typedef struct {
      string        tag;
      logic [127:0] exp;
   } expItem_t;

   expItem_t   sbQ[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] modelA [8];
   logic [7:0] modelB [16];

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pushExp(input string tag, input logic [127:0] exp);
      expItem_t item;
      item.tag = tag;
      item.exp = exp;
      sbQ.push_back(item);
   endtask

   task automatic popCheck(input logic [127:0] obs);
      expItem_t item;
      if (sbQ.size() == 0) begin
         checkOutput("sbEmpty", 128'(sbQ.size()), 128'd1);
      end else begin
         item = sbQ.pop_front();
         checkOutput(item.tag, obs, item.exp);
      end
   endtask

   function automatic logic [127:0] dumpA();
      logic [127:0] d = '0;
      for (int i = 0; i < 8; i++) d[(7-i)*8 +: 8] = modelA[i];
      return d;
   endfunction

   function automatic logic [127:0] dumpB();
      logic [127:0] d = '0;
      for (int i = 1; i < 16; i++) d[(15-i)*8 +: 8] = modelB[i];
      return d;
   endfunction

   task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
      busA.writeRegister = addr;
      busA.writeData     = data;
      busA.regWrite      = 1'b1;
      @(posedge clk); #1;
      busA.regWrite = 1'b0;
      modelA[addr]  = data;
   endtask

   task automatic writeB(input logic [3:0] addr, input logic [7:0] data);
      busB.writeRegister = addr;
      busB.writeData     = data;
      busB.regWrite      = 1'b1;
      @(posedge clk); #1;
      busB.regWrite = 1'b0;
      if (addr != 4'd0) modelB[addr] = data;
   endtask

   initial begin
      int busyCnt, doneCnt, dropCnt, firstBusy, doneAt, dropAt;

      busA.readRegister1 = '0; busA.readRegister2 = '0; busA.regWrite = 1'b0;
      busA.writeRegister = '0; busA.writeData = '0; busA.clrReq = 1'b0;
      busB.readRegister1 = '0; busB.readRegister2 = '0; busB.regWrite = 1'b0;
      busB.writeRegister = '0; busB.writeData = '0; busB.clrReq = 1'b0;
      for (int i = 0; i < 8; i++) modelA[i] = '0;
      for (int i = 0; i < 16; i++) modelB[i] = '0;
      rstA = 1'b0;
      rstB = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstA = 1'b1;
      rstB = 1'b1;

      // Preload, then pull reset in the middle of a cycle and expect zeros without any edge.
      applyStimulus(3'd1, 8'h77);
      busA.readRegister1 = 3'd1;
      busA.readRegister2 = 3'd1;
      #1;
      pushExp("preResetRd", 128'(modelA[1]));
      popCheck(128'(busA.readData1));
      rstA = 1'b0;
      for (int i = 0; i < 8; i++) modelA[i] = '0;
      #1;
      pushExp("rstRd1", 128'(modelA[1]));
      pushExp("rstRd2", 128'(modelA[1]));
      pushExp("rstDump", dumpA());
      pushExp("rstBusy", 128'd0);
      pushExp("rstDone", 128'd0);
      pushExp("rstDrop", 128'd0);
      popCheck(128'(busA.readData1));
      popCheck(128'(busA.readData2));
      popCheck(128'(busA.dataLookUp));
      popCheck(128'(busA.clrBusy));
      popCheck(128'(busA.clrDone));
      popCheck(128'(busA.wrDrop));
      @(negedge clk);
      rstA = 1'b1;

      // Read the target of a write in the same cycle: forwarded only when bypass is built in.
      busA.writeRegister = 3'd3;
      busA.writeData     = 8'hA5;
      busA.regWrite      = 1'b1;
      busA.readRegister1 = 3'd3;
      #1;
`ifdef REGBANK_BYPASS_EN
      pushExp("sameCycleRd", 128'h0A5);
`else
      pushExp("sameCycleRd", 128'(modelA[3]));
`endif
      popCheck(128'(busA.readData1));
      @(posedge clk); #1;
      busA.regWrite = 1'b0;
      modelA[3] = 8'hA5;
      pushExp("afterEdgeRd", 128'(modelA[3]));
      popCheck(128'(busA.readData1));
      applyStimulus(3'd7, 8'h3C);
      busA.readRegister1 = 3'd3;
      busA.readRegister2 = 3'd7;
      #1;
      pushExp("rdR3", 128'h0A5);
      pushExp("rdR7", 128'h03C);
      pushExp("dumpWr", dumpA());
      popCheck(128'(busA.readData1));
      popCheck(128'(busA.readData2));
      popCheck(128'(busA.dataLookUp));

      // Full sweep with a rejected write mid-sweep, then a write and an ignored clrReq during DONE.
      for (int i = 0; i < 8; i++) applyStimulus(3'(i), 8'hFF);
      pushExp("dumpFull", dumpA());
      popCheck(128'(busA.dataLookUp));
      busA.clrReq = 1'b1;
      @(posedge clk); #1;
      busA.clrReq = 1'b0;
      busyCnt = 0; doneCnt = 0; dropCnt = 0; firstBusy = -1; doneAt = -1; dropAt = -1;
      pushExp("sweepBusyCnt", 128'd8);
      pushExp("sweepFirstBusy", 128'd0);
      pushExp("sweepDoneCnt", 128'd1);
      pushExp("sweepDoneAt", 128'd8);
      pushExp("sweepDropCnt", 128'd1);
      pushExp("sweepDropAt", 128'd4);
      for (int i = 0; i < 20; i++) begin
         if (busA.clrBusy) begin busyCnt++; if (firstBusy < 0) firstBusy = i; end
         if (busA.clrDone) begin doneCnt++; doneAt = i; end
         if (busA.wrDrop)  begin dropCnt++; dropAt = i; end
         busA.regWrite = 1'b0;
         busA.clrReq   = 1'b0;
         if (i == 3) begin
            busA.regWrite = 1'b1; busA.writeRegister = 3'd1; busA.writeData = 8'h99;
         end
         if (i == 8) begin
            busA.clrReq = 1'b1;
            busA.regWrite = 1'b1; busA.writeRegister = 3'd2; busA.writeData = 8'h42;
         end
         @(posedge clk); #1;
      end
      popCheck(128'(busyCnt));
      popCheck(128'(firstBusy));
      popCheck(128'(doneCnt));
      popCheck(128'(doneAt));
      popCheck(128'(dropCnt));
      popCheck(128'(dropAt));
      for (int i = 0; i < 8; i++) modelA[i] = '0;
      modelA[2] = 8'h42;
      busA.readRegister1 = 3'd1;
      #1;
      pushExp("droppedWrRd", 128'(modelA[1]));
      pushExp("dumpAfterClr", dumpA());
      popCheck(128'(busA.readData1));
      popCheck(128'(busA.dataLookUp));

      // Zero register on bank B: the write vanishes without a drop pulse.
      writeB(4'd0, 8'h55);
      busB.readRegister1 = 4'd0;
      #1;
      pushExp("zeroRd", 128'd0);
      pushExp("zeroDrop", 128'd0);
      pushExp("zeroDumpMsb", 128'd0);
      popCheck(128'(busB.readData1));
      popCheck(128'(busB.wrDrop));
      popCheck(128'(busB.dataLookUp[127:120]));
      writeB(4'd15, 8'h66);
      writeB(4'd9, 8'h5A);
      busB.readRegister2 = 4'd15;
      #1;
      pushExp("bRdR15", 128'(modelB[15]));
      pushExp("bDump", dumpB());
      popCheck(128'(busB.readData2));
      popCheck(128'(busB.dataLookUp));

      // Abort a sweep with reset after five cycles; no done pulse may follow.
      busB.clrReq = 1'b1;
      @(posedge clk); #1;
      busB.clrReq = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      pushExp("midSweepBusy", 128'd1);
      popCheck(128'(busB.clrBusy));
      #2;
      rstB = 1'b0;
      for (int i = 0; i < 16; i++) modelB[i] = '0;
      #1;
      pushExp("abortBusy", 128'd0);
      pushExp("abortDump", dumpB());
      popCheck(128'(busB.clrBusy));
      popCheck(128'(busB.dataLookUp));
      busyCnt = 0; doneCnt = 0;
      pushExp("abortDoneCnt", 128'd0);
      for (int i = 0; i < 20; i++) begin
         if (i == 2) rstB = 1'b1;
         @(posedge clk); #1;
         if (busB.clrDone) doneCnt++;
      end
      popCheck(128'(doneCnt));

      // A fresh request after the abort runs the full 16-entry sweep.
      writeB(4'd4, 8'h11);
      busB.clrReq = 1'b1;
      @(posedge clk); #1;
      busB.clrReq = 1'b0;
      busyCnt = 0; doneCnt = 0; doneAt = -1;
      pushExp("sweepBBusyCnt", 128'd16);
      pushExp("sweepBDoneCnt", 128'd1);
      pushExp("sweepBDoneAt", 128'd16);
      for (int i = 0; i < 24; i++) begin
         if (busB.clrBusy) busyCnt++;
         if (busB.clrDone) begin doneCnt++; doneAt = i; end
         @(posedge clk); #1;
      end
      popCheck(128'(busyCnt));
      popCheck(128'(doneCnt));
      popCheck(128'(doneAt));
      for (int i = 0; i < 16; i++) modelB[i] = '0;
      pushExp("sweepBDump", dumpB());
      popCheck(128'(busB.dataLookUp));

      checkOutput("sbDrain", 128'(sbQ.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
